sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO, next generation of the team's byte FIFO used on the FT2 USB/SPI data path.
- Generalised data width and depth; uses extended pointers so all DEPTH entries are usable.
- Adds occupancy count, registered almost-full/almost-empty thresholds and a read-valid strobe.
- Optional sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param.sv | 133 +++++++++++++
 tb/tb_sync_fifo_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// registered full/empty/almost flags and a one-cycle read-valid strobe.
// Extended (ADDR_W+1)-bit pointers let all 2**ADDR_W entries be used.
// Optional build macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags
// cleared by err_clr_i; without it those outputs are tied low.

module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int AF_THRESH = 2040,
  parameter int AE_THRESH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [ADDR_W:0]   count_o,
  input  logic              err_clr_i,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              full_q, empty_q, af_q, ae_q;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still accepts a read
  // and an empty FIFO still accepts a write in the same cycle.
  assign wr_acc = wr_en_i & ~full_q;
  assign rd_acc = rd_en_i & ~empty_q;

  // Next-state for pointers, occupancy and the read-data register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(wr_acc);
    rd_ptr_d  = rd_ptr_q + (ADDR_W+1)'(rd_acc);
    count_d   = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    rd_data_d = rd_data_q;
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

  // Pointer, count, output and flag registers; flags follow count_d so they
  // line up with count_o in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_acc;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      af_q       <= (count_d >= AF_C);
      ae_q       <= (count_d <= AE_C);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags; a new error in the same cycle as err_clr_i wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en_i & full_q) begin
        ovf_q <= 1'b1;
      end else if (err_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (rd_en_i & empty_q) begin
        unf_q <= 1'b1;
      end else if (err_clr_i) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, AF=6, AE=1) using a
// queue-based scoreboard and a small occupancy model.

module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_en_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              rd_en_i = 1'b0;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              full_o, empty_o, almost_full_o, almost_empty_o;
  logic [ADDR_W:0]   count_o;
  logic              err_clr_i = 1'b0;
  logic              overflow_o, underflow_o;

  sync_fifo_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .err_clr_i(err_clr_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int errs = 0;

  // Scoreboard and reference model state.
  logic [DATA_W-1:0] sb[$];
  int                m_count = 0;
  logic [DATA_W-1:0] m_rd_data = '0;
  logic              m_valid = 1'b0;
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  // Drive one cycle of stimulus, update the model at the edge, settle 1 time unit.
  task automatic drive(input logic wr, input logic [DATA_W-1:0] d, input logic rd);
    logic wacc, racc;
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    @(posedge clk_i);
    wacc = wr && (m_count < DEPTH);
    racc = rd && (m_count > 0);
`ifdef SYNC_FIFO_ERR_EN
    if (wr && m_count == DEPTH) m_ovf = 1'b1;
    if (rd && m_count == 0)     m_unf = 1'b1;
`endif
    m_valid = racc;
    if (racc) m_rd_data = sb.pop_front();
    if (wacc) sb.push_back(d);
    m_count = m_count + int'(wacc) - int'(racc);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if (count_o !== '0) begin errs++; $display("FAIL reset_count: got %0d exp 0", count_o); end
    vecs++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errs++; $display("FAIL reset_empty_full: got %b/%b exp 1/0", empty_o, full_o); end
    vecs++; if (almost_empty_o !== 1'b1 || almost_full_o !== 1'b0) begin errs++; $display("FAIL reset_almost: got ae=%b af=%b exp 1/0", almost_empty_o, almost_full_o); end
    vecs++; if (rd_valid_o !== 1'b0 || rd_data_o !== 8'h00) begin errs++; $display("FAIL reset_rd: got v=%b d=%h exp 0/00", rd_valid_o, rd_data_o); end
    vecs++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errs++; $display("FAIL reset_err: got %b/%b exp 0/0", overflow_o, underflow_o); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'h11, 1'b0);
    vecs++; if (count_o !== 4'd1 || empty_o !== 1'b0 || almost_empty_o !== 1'b1) begin
      errs++; $display("FAIL single_write: got cnt=%0d e=%b ae=%b exp 1/0/1", count_o, empty_o, almost_empty_o); end
    vecs++; if (rd_valid_o !== 1'b0) begin errs++; $display("FAIL single_nov: got %b exp 0", rd_valid_o); end
    drive(1'b0, 8'h00, 1'b1);
    vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== m_rd_data || m_rd_data !== 8'h11) begin
      errs++; $display("FAIL single_read: got v=%b d=%h exp 1/%h", rd_valid_o, rd_data_o, m_rd_data); end
    vecs++; if (empty_o !== 1'b1 || count_o !== 4'd0) begin errs++; $display("FAIL single_empty: got e=%b cnt=%0d exp 1/0", empty_o, count_o); end
    drive(1'b0, 8'h00, 1'b0);
    vecs++; if (rd_valid_o !== 1'b0 || rd_data_o !== 8'h11) begin errs++; $display("FAIL single_hold: got v=%b d=%h exp 0/11", rd_valid_o, rd_data_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      vecs++; if (count_o !== 4'(m_count)) begin errs++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, count_o, m_count); end
      vecs++; if (almost_full_o !== (i + 1 >= AF)) begin errs++; $display("FAIL fill_af[%0d]: got %b exp %b", i, almost_full_o, (i + 1 >= AF)); end
      vecs++; if (full_o !== (i + 1 == DEPTH)) begin errs++; $display("FAIL fill_full[%0d]: got %b exp %b", i, full_o, (i + 1 == DEPTH)); end
      vecs++; if (almost_empty_o !== (i + 1 <= AE)) begin errs++; $display("FAIL fill_ae[%0d]: got %b exp %b", i, almost_empty_o, (i + 1 <= AE)); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hAA, 1'b0);
      vecs++; if (count_o !== 4'd8 || full_o !== 1'b1) begin errs++; $display("FAIL ovf_count: got cnt=%0d f=%b exp 8/1", count_o, full_o); end
      vecs++; if (overflow_o !== m_ovf) begin errs++; $display("FAIL ovf_flag: got %b exp %b", overflow_o, m_ovf); end
    end
  endtask

  task automatic test_full_rw();
    drive(1'b1, 8'hBB, 1'b1);
    vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== m_rd_data || m_rd_data !== 8'h00) begin
      errs++; $display("FAIL full_rw_data: got v=%b d=%h exp 1/00", rd_valid_o, rd_data_o); end
    vecs++; if (count_o !== 4'd7 || full_o !== 1'b0) begin errs++; $display("FAIL full_rw_count: got cnt=%0d f=%b exp 7/0", count_o, full_o); end
    while (m_count > 0) begin
      drive(1'b0, 8'h00, 1'b1);
      vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== m_rd_data) begin
        errs++; $display("FAIL drain_data: got v=%b d=%h exp 1/%h", rd_valid_o, rd_data_o, m_rd_data); end
    end
    drive(1'b0, 8'h00, 1'b1);
    vecs++; if (rd_valid_o !== 1'b0 || rd_data_o !== 8'h07 || count_o !== 4'd0) begin
      errs++; $display("FAIL underrun: got v=%b d=%h cnt=%0d exp 0/07/0", rd_valid_o, rd_data_o, count_o); end
    vecs++; if (underflow_o !== m_unf) begin errs++; $display("FAIL unf_flag: got %b exp %b", underflow_o, m_unf); end
  endtask

  task automatic test_empty_rw();
    logic [DATA_W-1:0] prev;
    prev = m_rd_data;
    drive(1'b1, 8'h5A, 1'b1);
    vecs++; if (count_o !== 4'd1 || rd_valid_o !== 1'b0 || rd_data_o !== prev) begin
      errs++; $display("FAIL empty_rw: got cnt=%0d v=%b d=%h exp 1/0/%h", count_o, rd_valid_o, rd_data_o, prev); end
    drive(1'b0, 8'h00, 1'b1);
    vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h5A) begin
      errs++; $display("FAIL empty_rw_read: got v=%b d=%h exp 1/5a", rd_valid_o, rd_data_o); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      vecs++; if (count_o !== 4'd5) begin errs++; $display("FAIL wrap_fill[%0d]: got %0d exp 5", r, count_o); end
      for (int k = 0; k < 5; k++) begin
        drive(1'b0, 8'h00, 1'b1);
        vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== m_rd_data) begin
          errs++; $display("FAIL wrap_data[%0d.%0d]: got v=%b d=%h exp 1/%h", r, k, rd_valid_o, rd_data_o, m_rd_data); end
      end
      vecs++; if (count_o !== 4'd0 || empty_o !== 1'b1) begin errs++; $display("FAIL wrap_empty[%0d]: got cnt=%0d e=%b exp 0/1", r, count_o, empty_o); end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 8'(8'hC0 + k), 1'b0);
    vecs++; if (count_o !== 4'd5) begin errs++; $display("FAIL arst_pre: got %0d exp 5", count_o); end
    #2 rst_i = 1'b1;
    #1;
    vecs++; if (count_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 || almost_empty_o !== 1'b1 || almost_full_o !== 1'b0) begin
      errs++; $display("FAIL arst_flags: got cnt=%0d e=%b f=%b ae=%b af=%b exp 0/1/0/1/0", count_o, empty_o, full_o, almost_empty_o, almost_full_o); end
    vecs++; if (rd_valid_o !== 1'b0 || rd_data_o !== 8'h00 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      errs++; $display("FAIL arst_out: got v=%b d=%h o=%b u=%b exp 0/00/0/0", rd_valid_o, rd_data_o, overflow_o, underflow_o); end
    #3 rst_i = 1'b0;
    sb.delete();
    m_count = 0; m_rd_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    vecs++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h3C || count_o !== 4'd0) begin
      errs++; $display("FAIL arst_after: got v=%b d=%h cnt=%0d exp 1/3c/0", rd_valid_o, rd_data_o, count_o); end
  endtask

  initial begin
    #12 rst_i = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
